// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// A 32-step shift-add multiplier and a 32-step restoring divider share one
// operand/accumulator datapath. Divide-by-zero and signed overflow are resolved
// when the instruction is accepted, so they skip the iterations entirely.
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic            flush_i,
    input  logic [9:0]      funct_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o
);

    localparam int CW = $clog2(ITERS);
    localparam logic [XLEN-1:0] L_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_acc;
    logic [4:0]      r_rd;
    logic            r_isRem;
    logic            r_negQ;
    logic            r_negR;
    logic            r_done;
    logic [XLEN-1:0] r_result;
    logic [4:0]      r_rdOut;

    logic [2:0]      w_f3;
    logic            w_isDiv;
    logic            w_isUns;
    logic            w_isRem;
    logic            w_accept;
    logic            w_divZero;
    logic            w_overflow;
    logic            w_special;
    logic            w_lastIter;
    logic [XLEN-1:0] w_absA;
    logic [XLEN-1:0] w_absB;
    logic [XLEN-1:0] w_specialRes;
    logic [XLEN-1:0] w_mulSum;
    logic [XLEN:0]   w_remShift;
    logic [XLEN:0]   w_diff;
    logic            w_qBit;
    logic [XLEN-1:0] w_remNext;
    logic [XLEN-1:0] w_quoFinal;
    logic [XLEN-1:0] w_quoSigned;
    logic [XLEN-1:0] w_remSigned;
    logic            w_unusedFunct7;

    // funct7 is already qualified upstream by req_i; only funct3 selects the op
    assign w_unusedFunct7 = &{1'b0, funct_i[9:3]};

    assign w_f3       = funct_i[2:0];
    assign w_isDiv    = w_f3[2];
    assign w_isUns    = w_f3[0];
    assign w_isRem    = w_f3[1];
    assign w_accept   = (r_state == S_IDLE) && req_i && !flush_i;
    assign w_divZero  = (rs2_data_i == '0);
    assign w_overflow = !w_isUns && (rs1_data_i == L_MIN) && (rs2_data_i == '1);
    assign w_special  = w_isDiv && (w_divZero || w_overflow);
    assign w_lastIter = (r_count == CW'(ITERS - 1));

    assign w_absA = (!w_isUns && rs1_data_i[XLEN-1]) ? -rs1_data_i : rs1_data_i;
    assign w_absB = (!w_isUns && rs2_data_i[XLEN-1]) ? -rs2_data_i : rs2_data_i;

    assign w_specialRes = w_divZero ? (w_isRem ? rs1_data_i : '1)
                                    : (w_isRem ? '0 : L_MIN);

    // Multiply step: r_a is the shifted multiplicand, r_b the multiplier bits
    assign w_mulSum = r_acc + (r_b[0] ? r_a : '0);

    // Restoring divide step: r_acc is the partial remainder, r_b shifts the
    // dividend out of its top while quotient bits enter at the bottom
    assign w_remShift  = {r_acc, r_b[XLEN-1]};
    assign w_diff      = w_remShift - {1'b0, r_a};
    assign w_qBit      = !w_diff[XLEN];
    assign w_remNext   = w_qBit ? w_diff[XLEN-1:0] : w_remShift[XLEN-1:0];
    assign w_quoFinal  = {r_b[XLEN-2:0], w_qBit};
    assign w_quoSigned = r_negQ ? -w_quoFinal : w_quoFinal;
    assign w_remSigned = r_negR ? -w_remNext : w_remNext;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; flush always wins over completion or acceptance
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_special)    w_nextState = S_DONE;
                    else if (w_isDiv) w_nextState = S_DIV;
                    else              w_nextState = S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                if (flush_i)         w_nextState = S_IDLE;
                else if (w_lastIter) w_nextState = S_DONE;
            end
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Stall: follows req_i while idle so ID_EX holds, forced during iterations
    always_comb begin
        stall_o = 1'b0;
        case (r_state)
            S_IDLE:       stall_o = req_i && !rst_i;
            S_MUL, S_DIV: stall_o = 1'b1;
            default:      stall_o = 1'b0;
        endcase
    end

    // Operand capture at acceptance and one iteration per cycle afterwards
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_rd    <= '0;
            r_isRem <= 1'b0;
            r_negQ  <= 1'b0;
            r_negR  <= 1'b0;
        end else if (w_accept) begin
            r_count <= '0;
            r_acc   <= '0;
            r_rd    <= rd_addr_i;
            r_isRem <= w_isRem;
            r_negQ  <= !w_isUns && (rs1_data_i[XLEN-1] ^ rs2_data_i[XLEN-1]);
            r_negR  <= !w_isUns && rs1_data_i[XLEN-1];
            if (w_isDiv) begin
                r_a <= w_absB;
                r_b <= w_absA;
            end else begin
                r_a <= rs1_data_i;
                r_b <= rs2_data_i;
            end
        end else if (r_state == S_MUL) begin
            r_acc   <= w_mulSum;
            r_a     <= r_a << 1;
            r_b     <= r_b >> 1;
            r_count <= r_count + CW'(1);
        end else if (r_state == S_DIV) begin
            r_acc   <= w_remNext;
            r_b     <= w_quoFinal;
            r_count <= r_count + CW'(1);
        end
    end

    // Registered result pulse, loaded on the edge that enters DONE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_done   <= 1'b0;
            r_result <= '0;
            r_rdOut  <= '0;
        end else begin
            r_done   <= 1'b0;
            r_result <= '0;
            r_rdOut  <= '0;
            if (w_nextState == S_DONE) begin
                r_done <= 1'b1;
                case (r_state)
                    S_IDLE: begin
                        r_result <= w_specialRes;
                        r_rdOut  <= rd_addr_i;
                    end
                    S_MUL: begin
                        r_result <= w_mulSum;
                        r_rdOut  <= r_rd;
                    end
                    default: begin
                        r_result <= r_isRem ? w_remSigned : w_quoSigned;
                        r_rdOut  <= r_rd;
                    end
                endcase
            end
        end
    end

    assign done_o    = r_done;
    assign result_o  = r_result;
    assign rd_addr_o = r_rdOut;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: self-checking bench for the iterative multiply/divide unit.
// Expected results come from plain SystemVerilog arithmetic on the operands.
module tb_ex_muldiv_unit;

    localparam int XLEN = 32;
    localparam int NORMAL_LAT = 33;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            req_i;
    logic            flush_i;
    logic [9:0]      funct_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic [4:0]      rd_addr_i;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_addr_o;

    int total = 0;
    int bad   = 0;

    ex_muldiv_unit #(.XLEN(XLEN), .ITERS(32)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .flush_i    (flush_i),
        .funct_i    (funct_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .rd_addr_i  (rd_addr_i),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .rd_addr_o  (rd_addr_o)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk_i = ~clk_i;

    // Safety net so the run can never hang
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // RV32M semantics written directly from the ISA rules
    function automatic logic [31:0] refResult(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        case (f3)
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            3'b111: begin
                if (b == 0) return a;
                return a % b;
            end
            default: return a * b;
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return NORMAL_LAT;
    endfunction

    // Issue one instruction in the current cycle and follow it to its result.
    // Leaves the bench at the start of the cycle after DONE with req_i still high.
    task automatic runOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input string tag);
        logic [31:0] expRes;
        int          expLat;
        int          doneCycle;
        int          stallCnt;
        logic        stallAtDone;
        logic [31:0] gotRes;
        logic [4:0]  gotRd;
        expRes      = refResult(f3, a, b);
        expLat      = refLatency(f3, a, b);
        doneCycle   = -1;
        stallAtDone = 1'bx;
        gotRes      = 'x;
        gotRd       = 'x;
        funct_i     = {7'b0000001, f3};
        rs1_data_i  = a;
        rs2_data_i  = b;
        rd_addr_i   = rd;
        flush_i     = 1'b0;
        req_i       = 1'b1;
        #1;
        stallCnt = (stall_o === 1'b1) ? 1 : 0;
        for (int k = 1; k <= 40 && doneCycle < 0; k++) begin
            @(posedge clk_i); #1;
            if (done_o === 1'b1) begin
                doneCycle   = k;
                stallAtDone = stall_o;
                gotRes      = result_o;
                gotRd       = rd_addr_o;
            end else begin
                if (stall_o === 1'b1) stallCnt++;
                rs1_data_i = $urandom;
                rs2_data_i = $urandom;
            end
        end
        total++;
        if (doneCycle !== expLat) begin
            bad++;
            $display("[TB] FAIL %s latency: got cycle %0d, expected cycle %0d", tag, doneCycle, expLat);
        end
        total++;
        if (stallCnt !== expLat) begin
            bad++;
            $display("[TB] FAIL %s stall_cycles: got %0d, expected %0d", tag, stallCnt, expLat);
        end
        total++;
        if (stallAtDone !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s stall_in_done: got %b, expected 0", tag, stallAtDone);
        end
        total++;
        if (gotRes !== expRes) begin
            bad++;
            $display("[TB] FAIL %s result: got 0x%08h, expected 0x%08h", tag, gotRes, expRes);
        end
        total++;
        if (gotRd !== rd) begin
            bad++;
            $display("[TB] FAIL %s rd_addr: got %0d, expected %0d", tag, gotRd, rd);
        end
        @(posedge clk_i); #1;
        total++;
        if (done_o !== 1'b0 || result_o !== 32'h0) begin
            bad++;
            $display("[TB] FAIL %s after_done: got done=%b result=0x%08h, expected done=0 result=0", tag, done_o, result_o);
        end
    endtask

    // Drop the request and confirm the unit sits quietly in idle for a cycle
    task automatic goIdle(input string tag);
        req_i   = 1'b0;
        flush_i = 1'b0;
        #1;
        total++;
        if (stall_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0) begin
            bad++;
            $display("[TB] FAIL %s idle: got stall=%b done=%b result=0x%08h, expected 0/0/0", tag, stall_o, done_o, result_o);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        total++;
        if (stall_o !== 1'b0 || done_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: got stall=%b done=%b, expected 0/0", stall_o, done_o);
        end
        total++;
        if (result_o !== 32'h0 || rd_addr_o !== 5'd0) begin
            bad++;
            $display("[TB] FAIL reset_data: got result=0x%08h rd=%0d, expected 0/0", result_o, rd_addr_o);
        end
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        total++;
        if (stall_o !== 1'b0 || done_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_release: got stall=%b done=%b, expected 0/0", stall_o, done_o);
        end
    endtask

    task automatic test_mul();
        runOp(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, "mul_7_x_m3");
        goIdle("mul");
    endtask

    task automatic test_div();
        runOp(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd1, "div_m7_2");
        goIdle("div");
        runOp(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd2, "rem_m7_2");
        goIdle("rem");
        runOp(3'b101, 32'd100, 32'd7, 5'd3, "divu_100_7");
        goIdle("divu");
        runOp(3'b111, 32'd100, 32'd7, 5'd4, "remu_100_7");
        goIdle("remu");
    endtask

    task automatic test_special();
        runOp(3'b101, 32'h8000_0000, 32'h0, 5'd10, "divu_by_zero");
        goIdle("divu_by_zero");
        runOp(3'b110, 32'h1234_5678, 32'h0, 5'd11, "rem_by_zero");
        goIdle("rem_by_zero");
        runOp(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, "div_overflow");
        goIdle("div_overflow");
        runOp(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, "rem_overflow");
        goIdle("rem_overflow");
        runOp(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, "divu_no_overflow");
        goIdle("divu_no_overflow");
    endtask

    task automatic test_unknown_funct3();
        runOp(3'b011, 32'h0001_0003, 32'h0000_0105, 5'd20, "funct3_011_as_mul");
        goIdle("funct3_011");
    endtask

    task automatic test_idle_flush();
        funct_i    = {7'b0000001, 3'b101};
        rs1_data_i = 32'd55;
        rs2_data_i = 32'd0;
        rd_addr_i  = 5'd7;
        req_i      = 1'b1;
        flush_i    = 1'b1;
        @(posedge clk_i); #1;
        req_i   = 1'b0;
        flush_i = 1'b0;
        #1;
        total++;
        if (done_o !== 1'b0 || stall_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_flush_blocks: got done=%b stall=%b, expected 0/0", done_o, stall_o);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_flush();
        logic sawDone;
        sawDone    = 1'b0;
        funct_i    = {7'b0000001, 3'b000};
        rs1_data_i = 32'd1234;
        rs2_data_i = 32'd5678;
        rd_addr_i  = 5'd6;
        flush_i    = 1'b0;
        req_i      = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk_i); #1;
            if (done_o === 1'b1) sawDone = 1'b1;
            if (k == 10) flush_i = 1'b1;
        end
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        req_i   = 1'b0;
        #1;
        if (done_o === 1'b1) sawDone = 1'b1;
        total++;
        if (sawDone !== 1'b0) begin
            bad++;
            $display("[TB] FAIL flush_no_done: got done pulse=%b, expected 0", sawDone);
        end
        total++;
        if (stall_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL flush_idle_stall: got %b, expected 0", stall_o);
        end
        runOp(3'b000, 32'd300, 32'd41, 5'd8, "after_flush_mul");
        goIdle("after_flush");
    endtask

    task automatic test_async_reset();
        logic sawDone;
        logic sawStall;
        sawDone    = 1'b0;
        sawStall   = 1'b0;
        funct_i    = {7'b0000001, 3'b100};
        rs1_data_i = 32'd1000;
        rs2_data_i = 32'd3;
        rd_addr_i  = 5'd9;
        flush_i    = 1'b0;
        req_i      = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk_i); #1;
        end
        req_i = 1'b0;
        #2;
        total++;
        if (stall_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL areset_busy: got stall=%b, expected 1", stall_o);
        end
        rst_i = 1'b1;
        #1;
        total++;
        if (stall_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0 || rd_addr_o !== 5'd0) begin
            bad++;
            $display("[TB] FAIL areset_outputs: got stall=%b done=%b result=0x%08h rd=%0d, expected all 0",
                     stall_o, done_o, result_o, rd_addr_o);
        end
        #3;
        rst_i = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk_i); #1;
            if (done_o === 1'b1) sawDone = 1'b1;
            if (stall_o === 1'b1) sawStall = 1'b1;
        end
        total++;
        if (sawDone !== 1'b0 || sawStall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL areset_stays_idle: got done=%b stall=%b, expected 0/0", sawDone, sawStall);
        end
    endtask

    task automatic test_back_to_back();
        runOp(3'b000, 32'hDEAD_BEEF, 32'h0000_0011, 5'd21, "b2b_first_mul");
        runOp(3'b111, 32'hDEAD_BEEF, 32'h0000_1000, 5'd22, "b2b_second_remu");
        runOp(3'b100, 32'h7FFF_FFFF, 32'h0000_0000, 5'd23, "b2b_third_divzero");
        goIdle("b2b");
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          sel;
        for (int n = 0; n < 25; n++) begin
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       b = 32'h0;
                1: begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
                2:       b = 32'($urandom_range(1, 15));
                3: begin
                    b = $urandom;
                    a = -a;
                end
                default: b = $urandom;
            endcase
            rd = 5'($urandom_range(0, 31));
            runOp(f3, a, b, rd, $sformatf("rand%0d_f%0d", n, f3));
            if ($urandom_range(0, 1) == 0) goIdle("rand");
        end
        goIdle("rand_end");
    endtask

    // Test sequence
    initial begin
        rst_i      = 1'b1;
        req_i      = 1'b0;
        flush_i    = 1'b0;
        funct_i    = '0;
        rs1_data_i = '0;
        rs2_data_i = '0;
        rd_addr_i  = '0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_unknown_funct3();
        test_idle_flush();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
